// File: rtl/gate_bank_sequencer.sv
// Sweeps the 16 {a,b,c,d} vectors into the primitive-gate bank and checks each settled response against the golden table.
// Optional macro GATE_SEQ_CAPTURE_EN adds a first-failure capture (vector index and raw bank outputs).
module gate_bank_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [9:0]  OUT_MASK   = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  output logic       gate_c,
  output logic       gate_d,
  input  logic [9:0] gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic [3:0] vec_idx
`ifdef GATE_SEQ_CAPTURE_EN
  ,
  output logic       first_fail_vld,
  output logic [3:0] first_fail_vec,
  output logic [9:0] first_fail_obs
`endif
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       vec_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [4:0]       mismatch_cnt_q;

  logic             va, vb, vc, vd;
  logic [9:0]       golden_d;
  logic             hit_d;
  logic [4:0]       mismatch_cnt_d;

  // The stimulus is the vector index itself, a being the MSB.
  assign {va, vb, vc, vd} = vec_idx_q;

  always_comb begin
    golden_d    = '0;
    golden_d[0] = va & vb;
    golden_d[1] = ~(vc & vd);
    golden_d[2] = va | vb | vc | vd;
    golden_d[3] = ~(vc | vd);
    golden_d[4] = va ^ vb ^ vc;
    golden_d[5] = ~(vb ^ vd);
    golden_d[6] = vc;
    golden_d[7] = ~vd;
    golden_d[8] = vc;
    golden_d[9] = va & vb;
  end

  assign hit_d          = |((gate_o ^ golden_d) & OUT_MASK);
  assign mismatch_cnt_d = hit_d ? (mismatch_cnt_q + 5'd1) : mismatch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      vec_idx_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      mismatch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q        <= ST_SETTLE;
            cnt_q          <= '0;
            vec_idx_q      <= '0;
            mismatch_cnt_q <= '0;
            pass_q         <= 1'b0;
            busy_q         <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          // An abort discards this vector's result; the partial count is kept.
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            mismatch_cnt_q <= mismatch_cnt_d;
            if (vec_idx_q == 4'hF) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (mismatch_cnt_d == 5'd0);
            end else begin
              vec_idx_q <= vec_idx_q + 4'd1;
              cnt_q     <= '0;
              state_q   <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gate_a       = va;
  assign gate_b       = vb;
  assign gate_c       = vc;
  assign gate_d       = vd;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign vec_idx      = vec_idx_q;

`ifdef GATE_SEQ_CAPTURE_EN
  logic       ff_vld_q;
  logic [3:0] ff_vec_q;
  logic [9:0] ff_obs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
      ff_obs_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
      ff_obs_q <= '0;
    end else if (state_q == ST_SAMPLE && !abort && hit_d && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_vec_q <= vec_idx_q;
      ff_obs_q <= gate_o;
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_obs = ff_obs_q;
`endif

endmodule
